// File: rtl/reg_file_sb_if.sv
// Decode-stage register file bus: read ports, issue/writeback tracking and hazard outputs.
// The master side is the pipeline (ID/WB), the slave side is the register file itself.
interface reg_file_sb_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int RD_PORTS = 2
);
    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS-1:0]        rd_en;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_busy;
    logic                       issue_en;
    logic [ADDR_W-1:0]          issue_dest;
    logic                       wb_en;
    logic [ADDR_W-1:0]          wb_dest;
    logic [DATA_W-1:0]          wb_value;
    logic                       flush;
    logic                       pend_full;
    logic                       hazard;

    modport master (
        output rd_addr, rd_en, issue_en, issue_dest, wb_en, wb_dest, wb_value, flush,
        input  rd_data, rd_busy, pend_full, hazard
    );

    modport slave (
        input  rd_addr, rd_en, issue_en, issue_dest, wb_en, wb_dest, wb_value, flush,
        output rd_data, rd_busy, pend_full, hazard
    );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Reads are combinational with write-through bypass; hazards are reported from the scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int RD_PORTS = 2,
    parameter int PEND_W   = 2
) (
    input logic         clk,
    input logic         rst,
    reg_file_sb_if.slave bus
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_reg  [NUM_REGS];
    logic [PEND_W-1:0] pend_reg  [NUM_REGS];
    logic [PEND_W-1:0] pend_next [NUM_REGS];

    logic wb_ok;
    logic issue_ok;
    logic [RD_PORTS*DATA_W-1:0] rd_data_w;
    logic [RD_PORTS-1:0]        rd_busy_w;
    logic [PEND_W-1:0]          issue_pend;
    logic                       pend_full_w;

    // Addresses beyond the implemented registers never touch data or counters.
    assign wb_ok    = bus.wb_en && (32'(bus.wb_dest) < NUM_REGS);
    assign issue_ok = bus.issue_en && (32'(bus.issue_dest) < NUM_REGS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            logic issue_hit;
            logic wb_hit;
            assign issue_hit = issue_ok && (bus.issue_dest == ADDR_W'(gi));
            assign wb_hit    = wb_ok && (bus.wb_dest == ADDR_W'(gi));
            // A same-cycle issue and writeback to one register cancel, even when saturated.
            assign pend_next[gi] =
                bus.flush                                             ? '0 :
                (issue_hit && !wb_hit && pend_reg[gi] != PEND_MAX)   ? pend_reg[gi] + PEND_ONE :
                (wb_hit && !issue_hit && pend_reg[gi] != '0)         ? pend_reg[gi] - PEND_ONE :
                                                                        pend_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= DATA_W'(i);
                pend_reg[i] <= '0;
            end
        end else begin
            if (wb_ok) begin
                regs_reg[bus.wb_dest] <= bus.wb_value;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_reg[i] <= pend_next[i];
            end
        end
    end

    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              in_range;
            logic              bypass;
            logic [DATA_W-1:0] stored;
            logic [PEND_W-1:0] pend_cur;
            assign addr     = bus.rd_addr[gi*ADDR_W +: ADDR_W];
            assign in_range = 32'(addr) < NUM_REGS;
            assign bypass   = wb_ok && (bus.wb_dest == addr);
            assign stored   = in_range ? regs_reg[addr] : '0;
            assign pend_cur = in_range ? pend_reg[addr] : '0;
            assign rd_data_w[gi*DATA_W +: DATA_W] = bypass ? bus.wb_value : stored;
            // The last outstanding write landing this cycle is bypassed, so the source is ready.
            assign rd_busy_w[gi] = bus.rd_en[gi] && (pend_cur != '0)
                                   && !(bypass && pend_cur == PEND_ONE);
        end
    endgenerate

    assign issue_pend  = issue_ok ? pend_reg[bus.issue_dest] : '0;
    assign pend_full_w = issue_ok && (issue_pend == PEND_MAX)
                         && !(wb_ok && bus.wb_dest == bus.issue_dest);

    assign bus.rd_data   = rd_data_w;
    assign bus.rd_busy   = rd_busy_w;
    assign bus.pend_full = pend_full_w;
    assign bus.hazard    = (|rd_busy_w) || (bus.issue_en && pend_full_w);
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios then randomized traffic,
// all outputs compared every cycle against a register/occupancy-count reference model.
module tb_reg_file_sb;
    localparam int DW   = 32;
    localparam int NR   = 16;
    localparam int AW   = 4;
    localparam int RP   = 2;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) bus ();

    reg_file_sb #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RD_PORTS(RP), .PEND_W(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_regs [NR];
    int            m_pend [NR];
    bit            m_valid = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        rst            = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_en      = '0;
        bus.issue_en   = 1'b0;
        bus.issue_dest = '0;
        bus.wb_en      = 1'b0;
        bus.wb_dest    = '0;
        bus.wb_value   = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        set_idle();
    endtask

    task automatic set_rd(input int a0, input bit e0, input int a1, input bit e1);
        bus.rd_addr = {AW'(a1), AW'(a0)};
        bus.rd_en   = {e1, e0};
    endtask

    task automatic set_wb(input int d, input logic [DW-1:0] v);
        bus.wb_en    = 1'b1;
        bus.wb_dest  = AW'(d);
        bus.wb_value = v;
    endtask

    task automatic set_issue(input int d);
        bus.issue_en   = 1'b1;
        bus.issue_dest = AW'(d);
    endtask

    // Compare the settled outputs with the model, then advance the model to the coming edge.
    task automatic cyc_end();
        int wd;
        int id;
        bit any_busy;
        bit exp_full;
        #1;
        wd = (bus.wb_en && int'(bus.wb_dest) < NR) ? int'(bus.wb_dest) : -1;
        id = (bus.issue_en && int'(bus.issue_dest) < NR) ? int'(bus.issue_dest) : -1;
        if (m_valid) begin
            any_busy = 1'b0;
            for (int k = 0; k < RP; k++) begin
                int a;
                logic [DW-1:0] exp_d;
                bit exp_b;
                a = int'(bus.rd_addr[k*AW +: AW]);
                if (a >= NR)      exp_d = '0;
                else if (a == wd) exp_d = bus.wb_value;
                else              exp_d = m_regs[a];
                exp_b = bus.rd_en[k] && a < NR && m_pend[a] > 0 && !(a == wd && m_pend[a] == 1);
                any_busy |= exp_b;
                check_val($sformatf("rd_data%0d", k), 64'(bus.rd_data[k*DW +: DW]), 64'(exp_d));
                check_val($sformatf("rd_busy%0d", k), 64'(bus.rd_busy[k]), 64'(exp_b));
            end
            exp_full = id >= 0 && m_pend[id] == PMAX && id != wd;
            check_val("pend_full", 64'(bus.pend_full), 64'(exp_full));
            check_val("hazard", 64'(bus.hazard), 64'(any_busy || (bus.issue_en && exp_full)));
        end
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = DW'(i);
                m_pend[i] = 0;
            end
            m_valid = 1'b1;
        end else begin
            if (wd >= 0) m_regs[wd] = bus.wb_value;
            if (bus.flush) begin
                for (int i = 0; i < NR; i++) m_pend[i] = 0;
            end else if (!(id >= 0 && id == wd)) begin
                if (id >= 0 && m_pend[id] < PMAX) m_pend[id]++;
                if (wd >= 0 && m_pend[wd] > 0)    m_pend[wd]--;
            end
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;

        // Reset, then read back the reset pattern.
        cyc_begin(); rst = 1'b1; cyc_end();
        cyc_begin(); set_rd(5, 1, 9, 1); cyc_end();
        check_val("rst_rd0", 64'(bus.rd_data[0 +: DW]), 64'd5);
        check_val("rst_rd1", 64'(bus.rd_data[DW +: DW]), 64'd9);
        check_val("rst_busy", 64'(bus.rd_busy), 64'd0);
        check_val("rst_hazard", 64'(bus.hazard), 64'd0);

        // Write-through bypass, then the stored value.
        cyc_begin(); set_rd(3, 0, 0, 0); set_wb(3, 32'hDEADBEEF); cyc_end();
        check_val("bypass_same", 64'(bus.rd_data[0 +: DW]), 64'hDEADBEEF);
        cyc_begin(); set_rd(3, 0, 0, 0); cyc_end();
        check_val("bypass_next", 64'(bus.rd_data[0 +: DW]), 64'hDEADBEEF);

        // RAW hazard on r7.
        cyc_begin(); set_issue(7); cyc_end();
        cyc_begin(); set_rd(7, 1, 0, 0); cyc_end();
        check_val("raw_busy", 64'(bus.rd_busy[0]), 64'd1);
        check_val("raw_hazard", 64'(bus.hazard), 64'd1);
        cyc_begin(); set_rd(7, 0, 0, 0); cyc_end();
        check_val("raw_unused", 64'(bus.hazard), 64'd0);
        cyc_begin(); set_rd(7, 1, 0, 0); set_wb(7, 32'h0000_0077); cyc_end();
        check_val("raw_wb_busy", 64'(bus.rd_busy[0]), 64'd0);
        check_val("raw_wb_data", 64'(bus.rd_data[0 +: DW]), 64'h77);

        // Saturating r2.
        repeat (3) begin cyc_begin(); set_issue(2); cyc_end(); end
        cyc_begin(); set_issue(2); cyc_end();
        check_val("sat_full", 64'(bus.pend_full), 64'd1);
        check_val("sat_hazard", 64'(bus.hazard), 64'd1);
        cyc_begin(); set_issue(2); set_wb(2, 32'h2); cyc_end();
        check_val("sat_iwb_full", 64'(bus.pend_full), 64'd0);
        for (int n = 0; n < 3; n++) begin
            cyc_begin(); set_rd(2, 1, 0, 0); set_wb(2, DW'(32'h200 + n)); cyc_end();
            check_val($sformatf("drain_busy%0d", n), 64'(bus.rd_busy[0]), (n == 2) ? 64'd0 : 64'd1);
        end

        // Flush drops tracking and the same-cycle issue.
        cyc_begin(); set_issue(4); cyc_end();
        cyc_begin(); set_issue(6); cyc_end();
        cyc_begin(); set_issue(8); bus.flush = 1'b1; cyc_end();
        cyc_begin(); set_rd(4, 1, 6, 1); cyc_end();
        check_val("flush_busy46", 64'(bus.rd_busy), 64'd0);
        cyc_begin(); set_rd(8, 1, 0, 0); cyc_end();
        check_val("flush_busy8", 64'(bus.rd_busy[0]), 64'd0);
        cyc_begin(); set_wb(4, 32'h44); cyc_end();
        cyc_begin(); set_rd(4, 1, 0, 0); cyc_end();
        check_val("flush_wb_data", 64'(bus.rd_data[0 +: DW]), 64'h44);
        check_val("flush_wb_busy", 64'(bus.rd_busy[0]), 64'd0);

        // Reset overrides an in-flight writeback.
        repeat (2) begin cyc_begin(); set_issue(1); cyc_end(); end
        cyc_begin(); rst = 1'b1; set_wb(1, 32'h55); cyc_end();
        cyc_begin(); set_rd(1, 1, 0, 0); cyc_end();
        check_val("midrst_data", 64'(bus.rd_data[0 +: DW]), 64'd1);
        check_val("midrst_busy", 64'(bus.rd_busy[0]), 64'd0);

        // Randomized traffic concentrated on a few registers to exercise the counters.
        for (int c = 0; c < 3000; c++) begin
            cyc_begin();
            rst = ($urandom_range(0, 299) == 0);
            set_rd($urandom_range(0, 2) == 0 ? $urandom_range(0, NR - 1) : $urandom_range(0, 3),
                   1'($urandom), $urandom_range(0, 3), 1'($urandom));
            if ($urandom_range(0, 1) == 1) set_issue($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) set_wb($urandom_range(0, 3), $urandom);
            bus.flush = ($urandom_range(0, 39) == 0);
            cyc_end();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
